// File: rtl/keypad_pkg.sv
// Shared constants, FSM state type and small bit helpers for the keypad scanner.
package keypad_pkg;
  localparam int NUM_COLS = 4;
  localparam int NUM_ROWS = 4;
  localparam int CODE_W   = 8;
  localparam logic [CODE_W-1:0] IDLE_CODE = 8'h00;

  typedef enum logic [1:0] {IDLE, CONFIRM, HELD, RELEASE} kp_state_e;

  // Isolate the lowest set bit (lowest row index wins).
  function automatic logic [NUM_ROWS-1:0] lowest_onehot(input logic [NUM_ROWS-1:0] v);
    lowest_onehot = v & (~v + NUM_ROWS'(1));
  endfunction

  // True when more than one bit is set.
  function automatic logic multi_hot(input logic [NUM_ROWS-1:0] v);
    multi_hot = (v & (v - NUM_ROWS'(1))) != '0;
  endfunction
endpackage

// File: rtl/keypad_scan_sync2.sv
// Two-flop synchronizer, parameterized width, for asynchronous keypad rows.
module sync2 #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);
  logic [WIDTH-1:0] r_meta;
  logic [WIDTH-1:0] r_sync;

  // Double-register the async input; cleared in reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_meta <= '0;
      r_sync <= '0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;
endmodule

// File: rtl/keypad_scan.sv
// 4x4 keypad scanner: column rotation on a scan tick, per-frame candidate
// code, and a frame-based debounce FSM producing a registered key code.
// Optional macro KEYSCAN_GHOST_REJECT_EN: frames with more than one pressed
// key yield an empty candidate instead of the lowest-column/lowest-row key.
module keypad_scan import keypad_pkg::*; #(
  parameter int CLK_HZ          = 50_000_000,
  parameter int SCAN_HZ         = 1_000,
  parameter int DEBOUNCE_FRAMES = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_ROWS-1:0] rows,
  output logic [NUM_COLS-1:0] cols,
  output logic [CODE_W-1:0]   diods,
  output logic                key_press
);
  localparam int DIV = CLK_HZ / SCAN_HZ;
  localparam int TW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int CW  = $clog2(DEBOUNCE_FRAMES + 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(DIV - 1);
  localparam logic [CW-1:0] CNT_MAX   = CW'(DEBOUNCE_FRAMES);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);

  logic [TW-1:0]       r_tick_cnt;
  logic [NUM_COLS-1:0] r_cols;
  logic [NUM_ROWS-1:0] w_rows_s;
  logic                w_tick;
  logic                w_frame_end;
  logic [NUM_ROWS-1:0] w_row_low;
  logic                w_hit;
  logic [NUM_COLS-1:0] w_col_onehot;
  logic [CODE_W-1:0]   w_samp_code;
  logic [CODE_W-1:0]   w_cand_code;
  logic [CODE_W-1:0]   w_cand;
  logic                r_acc_found;
  logic [CODE_W-1:0]   r_acc_code;

  kp_state_e           r_state, w_state_nx;
  logic [CW-1:0]       r_frame_cnt, w_cnt_nx, w_cnt_inc;
  logic [CODE_W-1:0]   r_pend, w_pend_nx;
  logic [CODE_W-1:0]   r_diods, w_diods_nx;
  logic                r_press, w_press_nx;

  sync2 #(.WIDTH(NUM_ROWS)) u_sync (
    .clk (clk),
    .rst (rst),
    .i_d (rows),
    .o_q (w_rows_s)
  );

  assign w_tick       = (r_tick_cnt == TICK_LAST);
  assign w_frame_end  = w_tick && !r_cols[NUM_COLS-1];
  assign w_col_onehot = ~r_cols;
  assign w_row_low    = ~w_rows_s;
  assign w_hit        = |w_row_low;
  assign w_samp_code  = {w_col_onehot, lowest_onehot(w_row_low)};
  // Earlier columns take priority; the current sample only counts if nothing was seen yet.
  assign w_cand_code  = r_acc_found ? r_acc_code : (w_hit ? w_samp_code : IDLE_CODE);

`ifdef KEYSCAN_GHOST_REJECT_EN
  logic r_acc_multi;
  logic w_multi;
  assign w_multi = r_acc_multi | multi_hot(w_row_low) | (r_acc_found & w_hit);
  assign w_cand  = w_multi ? IDLE_CODE : w_cand_code;

  // Remember whether more than one key has been seen in the current frame.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)             r_acc_multi <= 1'b0;
    else if (w_frame_end) r_acc_multi <= 1'b0;
    else if (w_tick)      r_acc_multi <= w_multi;
  end
`else
  assign w_cand = w_cand_code;
`endif

  // Scan tick divider; wraps to 0 on the tick.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)        r_tick_cnt <= '0;
    else if (w_tick) r_tick_cnt <= '0;
    else             r_tick_cnt <= r_tick_cnt + TW'(1);
  end

  // Rotate the single low column on each tick, starting at column 0.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)        r_cols <= 4'b1110;
    else if (w_tick) r_cols <= {r_cols[NUM_COLS-2:0], r_cols[NUM_COLS-1]};
  end

  // Accumulate the first hit of the frame; cleared at every frame end.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_acc_found <= 1'b0;
      r_acc_code  <= IDLE_CODE;
    end else if (w_frame_end) begin
      r_acc_found <= 1'b0;
      r_acc_code  <= IDLE_CODE;
    end else if (w_tick && !r_acc_found && w_hit) begin
      r_acc_found <= 1'b1;
      r_acc_code  <= w_samp_code;
    end
  end

  assign w_cnt_inc = (r_frame_cnt >= CNT_MAX) ? r_frame_cnt : r_frame_cnt + CNT_ONE;

  // Debounce FSM state and outputs register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= IDLE;
      r_frame_cnt <= '0;
      r_pend      <= IDLE_CODE;
      r_diods     <= IDLE_CODE;
      r_press     <= 1'b0;
    end else begin
      r_state     <= w_state_nx;
      r_frame_cnt <= w_cnt_nx;
      r_pend      <= w_pend_nx;
      r_diods     <= w_diods_nx;
      r_press     <= w_press_nx;
    end
  end

  // Debounce decisions, taken only at frame end.
  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_frame_cnt;
    w_pend_nx  = r_pend;
    w_diods_nx = r_diods;
    w_press_nx = 1'b0;
    if (w_frame_end) begin
      unique case (r_state)
        IDLE: if (w_cand != IDLE_CODE) begin
          if (CNT_ONE >= CNT_MAX) begin
            w_state_nx = HELD;
            w_diods_nx = w_cand;
            w_press_nx = 1'b1;
            w_cnt_nx   = '0;
          end else begin
            w_state_nx = CONFIRM;
            w_pend_nx  = w_cand;
            w_cnt_nx   = CNT_ONE;
          end
        end
        CONFIRM: begin
          if (w_cand == IDLE_CODE) begin
            w_state_nx = IDLE;
            w_cnt_nx   = '0;
          end else if (w_cand != r_pend) begin
            w_pend_nx  = w_cand;
            w_cnt_nx   = CNT_ONE;
          end else if (w_cnt_inc >= CNT_MAX) begin
            w_state_nx = HELD;
            w_diods_nx = r_pend;
            w_press_nx = 1'b1;
            w_cnt_nx   = '0;
          end else begin
            w_cnt_nx   = w_cnt_inc;
          end
        end
        HELD: if (w_cand != r_diods) begin
          if (CNT_ONE >= CNT_MAX) begin
            w_state_nx = IDLE;
            w_diods_nx = IDLE_CODE;
            w_cnt_nx   = '0;
          end else begin
            w_state_nx = RELEASE;
            w_cnt_nx   = CNT_ONE;
          end
        end
        RELEASE: begin
          if (w_cand == r_diods) begin
            w_state_nx = HELD;
            w_cnt_nx   = '0;
          end else if (w_cnt_inc >= CNT_MAX) begin
            w_state_nx = IDLE;
            w_diods_nx = IDLE_CODE;
            w_cnt_nx   = '0;
          end else begin
            w_cnt_nx   = w_cnt_inc;
          end
        end
        default: w_state_nx = IDLE;
      endcase
    end
  end

  assign cols      = r_cols;
  assign diods     = r_diods;
  assign key_press = r_press;
endmodule

// File: tb/tb_keypad_scan.sv
// Bench for keypad_scan: a physical key-matrix model drives rows from cols;
// a frame-level reference model predicts the accepted code and press pulses.
module tb_keypad_scan;
  localparam int DF = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] rows;
  logic [3:0] cols;
  logic [7:0] diods;
  logic       key_press;

  logic [3:0][3:0] keys = '0;  // keys[col][row]

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state
  logic [7:0] m_acc  = 8'h00;
  logic [7:0] m_last = 8'h00;
  int         m_run  = 0;
  int         m_diff = 0;

  keypad_scan #(.CLK_HZ(1000), .SCAN_HZ(100), .DEBOUNCE_FRAMES(DF)) dut (
    .clk       (clk),
    .rst       (rst),
    .rows      (rows),
    .cols      (cols),
    .diods     (diods),
    .key_press (key_press)
  );

  always #5 clk = ~clk;

  // Matrix: a pressed key pulls its row low while its column is driven low.
  always_comb begin
    rows = 4'hF;
    for (int c = 0; c < 4; c++)
      if (!cols[c])
        for (int r = 0; r < 4; r++)
          if (keys[c][r]) rows[r] = 1'b0;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  function automatic logic [7:0] ref_cand(input logic [3:0][3:0] k);
    int n = 0;
    logic [7:0] code = 8'h00;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        if (k[c][r]) begin
          n++;
          if (code == 8'h00) code = {4'(1 << c), 4'(1 << r)};
        end
`ifdef KEYSCAN_GHOST_REJECT_EN
    if (n > 1) code = 8'h00;
`endif
    return code;
  endfunction

  // Run-length view of debouncing: accept after DF identical nonzero frames,
  // drop after DF consecutive frames that differ from the accepted code.
  task automatic model_frame(input logic [3:0][3:0] k, output logic [7:0] ed, output logic ep);
    logic [7:0] cand;
    cand = ref_cand(k);
    ep = 1'b0;
    if (m_acc == 8'h00) begin
      if (cand == 8'h00)        m_run = 0;
      else if (cand == m_last)  m_run++;
      else                      m_run = 1;
      m_last = cand;
      if (m_run >= DF) begin
        m_acc = cand; ep = 1'b1; m_diff = 0;
      end
    end else begin
      if (cand != m_acc) m_diff++; else m_diff = 0;
      if (m_diff >= DF) begin
        m_acc = 8'h00; m_run = 0; m_last = 8'h00; m_diff = 0;
      end
    end
    ed = m_acc;
  endtask

  task automatic model_reset();
    m_acc = 8'h00; m_last = 8'h00; m_run = 0; m_diff = 0;
  endtask

  // Apply one key set for a whole frame and check the frame-end outcome.
  task automatic do_frame(input logic [3:0][3:0] k, input string tag);
    logic [7:0] ed;
    logic       ep;
    int         pulses = 0;
    logic [3:0] prev;
    bit         done = 0;
    keys = k;
    model_frame(k, ed, ep);
    prev = cols;
    for (int i = 0; i < 60 && !done; i++) begin
      @(negedge clk);
      if (key_press) pulses++;
      if (prev == 4'b0111 && cols == 4'b1110) done = 1;
      prev = cols;
    end
    n_cmp++;
    if (!done) begin
      n_err++;
      $display("FAIL %s frame_end: no frame boundary within 60 cycles", tag);
    end
    n_cmp++;
    if (diods !== ed) begin
      n_err++;
      $display("FAIL %s diods: got %h expected %h (keys %h)", tag, diods, ed, k);
    end
    n_cmp++;
    if (pulses != int'(ep)) begin
      n_err++;
      $display("FAIL %s key_press: got %0d pulses expected %0d", tag, pulses, int'(ep));
    end
  endtask

  task automatic test_reset();
    int last, n;
    logic [3:0] exp_seq [4];
    exp_seq[0] = 4'b1101; exp_seq[1] = 4'b1011; exp_seq[2] = 4'b0111; exp_seq[3] = 4'b1110;
    keys = '0;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (cols !== 4'b1110 || diods !== 8'h00 || key_press !== 1'b0) begin
      n_err++;
      $display("FAIL reset_state: cols=%b diods=%h kp=%b expected 1110/00/0", cols, diods, key_press);
    end
    rst = 1'b1;
    last = 0; n = 0;
    for (int j = 0; j < 4; j++) begin
      logic [3:0] prev;
      bit seen = 0;
      prev = cols;
      for (int i = 0; i < 30 && !seen; i++) begin
        @(negedge clk);
        n++;
        if (cols != prev) seen = 1;
      end
      n_cmp++;
      if (!seen || (n - last) != 10 || cols !== exp_seq[j]) begin
        n_err++;
        $display("FAIL reset_rotate[%0d]: cols=%b after %0d cycles expected %b after 10", j, cols, n - last, exp_seq[j]);
      end
      last = n;
    end
    model_reset();
  endtask

  task automatic test_clean_press();
    logic [3:0][3:0] k = '0;
    k[0][0] = 1'b1;
    for (int i = 0; i < 5; i++) do_frame(k, "clean_press");
    n_cmp++;
    if (diods !== 8'h11) begin
      n_err++;
      $display("FAIL clean_press_code: got %h expected 11", diods);
    end
    for (int i = 0; i < 3; i++) do_frame('0, "clean_release");
  endtask

  task automatic test_bounce();
    logic [3:0][3:0] k = '0;
    k[2][1] = 1'b1;
    for (int i = 0; i < 5; i++) do_frame((i % 2 == 0) ? k : '0, "bounce");
    for (int i = 0; i < 4; i++) do_frame(k, "bounce_steady");
    n_cmp++;
    if (diods !== 8'h42) begin
      n_err++;
      $display("FAIL bounce_code: got %h expected 42", diods);
    end
    for (int i = 0; i < 3; i++) do_frame('0, "bounce_release");
  endtask

  task automatic test_glitch();
    logic [3:0][3:0] k = '0;
    k[0][0] = 1'b1;
    for (int i = 0; i < 4; i++) do_frame(k, "glitch_press");
    do_frame('0, "glitch_gap");
    for (int i = 0; i < 3; i++) do_frame(k, "glitch_hold");
    n_cmp++;
    if (diods !== 8'h11) begin
      n_err++;
      $display("FAIL glitch_code: got %h expected 11", diods);
    end
    for (int i = 0; i < 3; i++) do_frame('0, "glitch_release");
  endtask

  task automatic test_two_key();
    logic [3:0][3:0] k = '0;
    logic [7:0] exp_code;
`ifdef KEYSCAN_GHOST_REJECT_EN
    exp_code = 8'h00;
`else
    exp_code = 8'h11;
`endif
    k[0][0] = 1'b1;
    k[1][2] = 1'b1;
    for (int i = 0; i < 4; i++) do_frame(k, "two_key");
    n_cmp++;
    if (diods !== exp_code) begin
      n_err++;
      $display("FAIL two_key_code: got %h expected %h", diods, exp_code);
    end
    for (int i = 0; i < 3; i++) do_frame('0, "two_key_release");
  endtask

  task automatic test_mid_reset();
    logic [3:0][3:0] k = '0;
    k[0][0] = 1'b1;
    for (int i = 0; i < 2; i++) do_frame(k, "midrst_confirm");
    repeat (15) @(negedge clk);
    rst = 1'b0;
    #1;
    n_cmp++;
    if (cols !== 4'b1110 || diods !== 8'h00 || key_press !== 1'b0) begin
      n_err++;
      $display("FAIL midrst_async: cols=%b diods=%h kp=%b expected 1110/00/0", cols, diods, key_press);
    end
    repeat (3) @(negedge clk);
    rst = 1'b1;
    model_reset();
    for (int i = 0; i < 3; i++) do_frame(k, "midrst_redebounce");
    n_cmp++;
    if (diods !== 8'h11) begin
      n_err++;
      $display("FAIL midrst_code: got %h expected 11", diods);
    end
    for (int i = 0; i < 3; i++) do_frame('0, "midrst_release");
  endtask

  task automatic test_random();
    logic [3:0][3:0] k = '0;
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(99) >= 60) begin
        int sel = $urandom_range(99);
        k = '0;
        if (sel >= 40) k[$urandom_range(3)][$urandom_range(3)] = 1'b1;
        if (sel >= 85) k[$urandom_range(3)][$urandom_range(3)] = 1'b1;
      end
      do_frame(k, "random");
    end
    for (int i = 0; i < 3; i++) do_frame('0, "random_release");
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_bounce();
    test_glitch();
    test_two_key();
    test_mid_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/keypad_scan.md
KEYPAD_SCAN -- requirements
Module: keypad_scan

Interface
REQ-001 SHALL have parameter CLK_HZ, default 50_000_000, meaning system clock frequency in Hz.
REQ-002 SHALL have parameter SCAN_HZ, default 1_000, meaning column-advance tick rate in Hz.
REQ-003 SHALL have parameter DEBOUNCE_FRAMES, default 4, meaning the number of consecutive identical full scan frames required to accept a press or release.
REQ-004 SHALL have port clk, input, 1 bit: the single system clock; all logic is on the rising edge.
REQ-005 SHALL have port rst, input, 1 bit: asynchronous active-low reset; one clock; rst asserts asynchronously and deasserts synchronously to clk.
REQ-006 SHALL have port rows, input, 4 bits: keypad row lines, active-low, externally pulled up, asynchronous to clk.
REQ-007 SHALL have port cols, output, 4 bits: keypad column drive, active-low, exactly one bit low at all times.
REQ-008 SHALL have port diods, output, 8 bits: accepted key code {col_onehot[3:0], row_onehot[3:0]}, active-high, 8'h00 when no key is held.
REQ-009 SHALL have port key_press, output, 1 bit: one-cycle pulse when a new key code is accepted.

Function
REQ-010 SHALL generate a scan tick every CLK_HZ/SCAN_HZ clk cycles using an internal counter that wraps to 0 on the tick.
REQ-011 SHALL pass rows through a 2-flop synchronizer before any use.
REQ-012 SHALL, on each tick, sample the synchronized rows for the currently driven column, then rotate cols (1110 -> 1101 -> 1011 -> 0111 -> 1110) in the same cycle.
REQ-013 SHALL form a candidate code after the column-3 sample: col one-hot of the column that had a low row, and row one-hot = inverted sampled rows.
REQ-014 SHALL set the candidate to 8'h00 when no row was low in any column during the frame.
REQ-015 SHALL resolve multiple low rows or columns, when KEYSCAN_GHOST_REJECT_EN is undefined, to the lowest column index, then the lowest row index.
REQ-016 SHALL implement FSM states IDLE, CONFIRM, HELD and RELEASE, evaluated once per frame end.
REQ-017 SHALL transition IDLE -> CONFIRM when the candidate is nonzero, latching it as the pending code and setting frame_cnt=1.
REQ-018 SHALL, in CONFIRM, increment frame_cnt while the candidate equals the pending code; on reaching DEBOUNCE_FRAMES it SHALL enter HELD, set diods to the pending code and pulse key_press.
REQ-019 SHALL, in CONFIRM, return to IDLE if the candidate is 8'h00, or restart CONFIRM with the new code if the candidate is a different nonzero code.
REQ-020 SHALL transition HELD -> RELEASE with frame_cnt=1 when the candidate differs from diods.
REQ-021 SHALL, in RELEASE, return to HELD if the candidate equals diods again, without pulsing key_press.
REQ-022 SHALL, in RELEASE, after DEBOUNCE_FRAMES consecutive differing frames, clear diods to 8'h00 and enter IDLE; a new key SHALL then be processed from IDLE.
REQ-023 SHALL register diods, so it changes only in the cycle after a frame-end decision; latency from a stable press to diods is at most (DEBOUNCE_FRAMES+1) frames plus 3 cycles.
REQ-024 SHALL keep frame_cnt saturating, with width $clog2(DEBOUNCE_FRAMES+1).

Reset
REQ-025 SHALL, while rst is low, set cols=4'b1110, diods=8'h00, key_press=0, FSM=IDLE, and clear all counters and synchronizer flops.
REQ-026 SHALL, on reset asserted mid-scan or mid-debounce, abandon the current frame; the first post-reset frame SHALL start at column 0.

Configuration
REQ-027 SHALL, when KEYSCAN_GHOST_REJECT_EN is defined, force the candidate to 8'h00 for any frame in which more than one key reads pressed; when it is undefined, REQ-015 priority SHALL apply.

Structure
REQ-028 SHALL place the state enum, NUM_COLS=4, NUM_ROWS=4, CODE_W=8 and the idle code 8'h00 in shared package keypad_pkg.
REQ-029 SHALL implement the synchronizer as sub-module sync2 (parameterized width); tick, scan and FSM logic SHALL remain in keypad_scan.

Verification
Bench parameters for all scenarios: CLK_HZ=1000, SCAN_HZ=100 (tick every 10 cycles), DEBOUNCE_FRAMES=3.
REQ-030 SHALL cover reset: rst low -> cols=1110 and diods=00; after release, cols rotates every 10 cycles.
REQ-031 SHALL cover a clean press: key col0/row0 held steady -> diods=8'h11 and a single key_press pulse within 4 frames; release -> diods=00 after 3 frames.
REQ-032 SHALL cover bounce: key col2/row1 toggling every frame for 5 frames, then steady -> no key_press during bouncing, then diods=8'h42.
REQ-033 SHALL cover a short glitch: in HELD with 8'h11, 1 frame with no key -> diods stays 8'h11 and key_press does not pulse.
REQ-034 SHALL cover a two-key press: col0/row0 plus col1/row2 -> diods=8'h11 without the macro, and diods=8'h00 with KEYSCAN_GHOST_REJECT_EN defined.
REQ-035 SHALL cover mid-debounce reset: rst pulsed during CONFIRM -> diods=00, FSM=IDLE, and the press is re-debounced from frame 1.
